// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO, issue stage and in-order result buffer
// sitting in front of a one-cycle registered 16-bit ALU.
module alu_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int RES_DEPTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_parity,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_divzero,
    output logic [2:0]  cmd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] SEL_IDLE = 4'b1111;

    logic [3:0]    fifo_op [DEPTH];
    logic [15:0]   fifo_a  [DEPTH];
    logic [15:0]   fifo_b  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;

    logic v0, dz0, v1, dz1;

    logic [15:0] rb_data  [RES_DEPTH];
    logic [3:0]  rb_flags [RES_DEPTH];
    logic        rb_dz    [RES_DEPTH];
    logic [1:0]  rb_wp;
    logic [1:0]  rb_rp;
    logic [1:0]  rb_cnt;

    logic       full, empty, push, issue, res_pop, head_div0;
    logic [2:0] outstanding;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = ready_en & ~full;
    assign push      = cmd_valid & cmd_ready;

    // a same-cycle result pop is not credited until the next cycle
    assign outstanding = {2'b0, v0} + {2'b0, v1} + {1'b0, rb_cnt};
    assign issue       = ~empty & (outstanding < 3'(RES_DEPTH));
    assign head_div0   = (fifo_op[rd_ptr] == OP_DIV) && (fifo_b[rd_ptr] == 16'd0);

    assign res_valid   = (rb_cnt != 2'd0);
    assign res_pop     = res_valid & res_ready;
    assign res_data    = res_valid ? rb_data[rb_rp]  : 16'd0;
    assign res_flags   = res_valid ? rb_flags[rb_rp] : 4'd0;
    assign res_divzero = res_valid & rb_dz[rb_rp];
    assign cmd_count   = 3'(count);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !issue)
                count <= count + 1'b1;
            else if (!push && issue)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_a   <= 16'd0;
            alu_b   <= 16'd0;
            alu_sel <= SEL_IDLE;
            v0      <= 1'b0;
            dz0     <= 1'b0;
            v1      <= 1'b0;
            dz1     <= 1'b0;
        end else begin
            v0  <= issue;
            dz0 <= issue & head_div0;
            v1  <= v0;
            dz1 <= dz0;
            if (issue) begin
                alu_a   <= fifo_a[rd_ptr];
                alu_b   <= head_div0 ? 16'd1 : fifo_b[rd_ptr];
                alu_sel <= fifo_op[rd_ptr];
            end else begin
                alu_sel <= SEL_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (v1) begin
            rb_data[rb_wp]  <= dz1 ? 16'hFFFF : alu_result;
            rb_flags[rb_wp] <= dz1 ? 4'b0000
                                   : {alu_carry, alu_zero, alu_sign, alu_parity};
            rb_dz[rb_wp]    <= dz1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rb_wp  <= 2'd0;
            rb_rp  <= 2'd0;
            rb_cnt <= 2'd0;
        end else begin
            if (v1)
                rb_wp <= (rb_wp == 2'(RES_DEPTH - 1)) ? 2'd0 : rb_wp + 2'd1;
            if (res_pop)
                rb_rp <= (rb_rp == 2'(RES_DEPTH - 1)) ? 2'd0 : rb_rp + 2'd1;
            if (v1 && !res_pop)
                rb_cnt <= rb_cnt + 2'd1;
            else if (!v1 && res_pop)
                rb_cnt <= rb_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: random and directed checks of alu_issue_queue
// against a queue-based reference and a behavioural registered ALU.
module tb_alu_issue_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result = 16'd0;
    logic        alu_carry = 1'b0;
    logic        alu_zero = 1'b0;
    logic        alu_sign = 1'b0;
    logic        alu_parity = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [3:0]  res_flags;
    logic        res_divzero;
    logic [2:0]  cmd_count;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int pops = 0;
    logic [20:0] expq[$];

    alu_issue_queue dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_parity(alu_parity),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .res_divzero(res_divzero), .cmd_count(cmd_count)
    );

    always #5 clock = ~clock;

    // {result, carry, zero, sign, parity}
    function automatic logic [19:0] alu_fn(logic [3:0] op, logic [15:0] a,
                                           logic [15:0] b);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] r;
        logic        c;
        w = 17'd0;
        p = 32'd0;
        r = 16'd0;
        c = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; end
            4'd2: begin p = a * b; r = p[15:0]; c = |p[31:16]; end
            4'd3: begin r = (b == 16'd0) ? 16'd0 : a / b; end
            4'd4: begin w = {1'b0, a} + 17'd1; r = w[15:0]; c = w[16]; end
            4'd5: begin w = {1'b0, a} - 17'd1; r = w[15:0]; c = w[16]; end
            default: r = 16'd0;
        endcase
        return {r, c, (r == 16'd0), r[15], ~^r};
    endfunction

    function automatic logic [20:0] expect_of(logic [3:0] op, logic [15:0] a,
                                              logic [15:0] b);
        if (op == 4'd3 && b == 16'd0)
            return {16'hFFFF, 4'b0000, 1'b1};
        return {alu_fn(op, a, b), 1'b0};
    endfunction

    always @(posedge clock)
        {alu_result, alu_carry, alu_zero, alu_sign, alu_parity} <=
            alu_fn(alu_sel, alu_a, alu_b);

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // called at a negedge with inputs set; advances to the next negedge
    task automatic step();
        logic [20:0] e;
        if (cmd_valid && cmd_ready) begin
            expq.push_back(expect_of(cmd_op, cmd_a, cmd_b));
            accepts++;
        end
        if (res_valid && res_ready) begin
            pops++;
            if (expq.size() == 0) begin
                check("spurious_res", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check("res_order", {11'd0, res_data, res_flags, res_divzero},
                      {11'd0, e});
            end
        end
        @(negedge clock);
    endtask

    task automatic run_one(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                           logic [15:0] xd, logic [3:0] xf, logic xz,
                           logic [15:0] xb);
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        step();
        cmd_valid = 1'b0;
        step();
        check("issue_sel", {28'd0, alu_sel}, {28'd0, op});
        check("issue_b", {16'd0, alu_b}, {16'd0, xb});
        check("lat_e1", {31'd0, res_valid}, 32'd0);
        step();
        check("lat_e2", {31'd0, res_valid}, 32'd0);
        step();
        check("lat_e3", {31'd0, res_valid}, 32'd1);
        check("dir_data", {16'd0, res_data}, {16'd0, xd});
        check("dir_flags", {28'd0, res_flags}, {28'd0, xf});
        check("dir_dz", {31'd0, res_divzero}, {31'd0, xz});
        step();
        check("dir_empty", {31'd0, res_valid}, 32'd0);
    endtask

    task automatic rand_cmd();
        cmd_op = 4'($urandom_range(0, 5));
        cmd_a = 16'($urandom);
        cmd_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    endtask

    task automatic drain(string tag);
        int base;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 40 && expq.size() > 0; c++)
            step();
        check(tag, expq.size(), 32'd0);
        base = pops;
        step();
        check({tag, "_extra"}, pops - base, 32'd0);
    endtask

    logic [3:0]  bp_op [8];
    logic [15:0] bp_a  [8];
    logic [15:0] bp_b  [8];
    int n_acc;
    int sent;
    logic acc;

    initial begin
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_sel", {28'd0, alu_sel}, 32'hF);
        check("rst_ab", {alu_a, alu_b}, 32'd0);
        check("rst_res", {11'd0, res_valid, res_data, res_flags, res_divzero}, 32'd0);
        check("rst_count", {29'd0, cmd_count}, 32'd0);
        reset = 1'b1;
        step();
        check("rel_ready", {31'd0, cmd_ready}, 32'd1);

        run_one(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1101, 1'b0, 16'h0001);
        run_one(4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b0, 16'h0005);
        run_one(4'd3, 16'h0010, 16'h0000, 16'hFFFF, 4'b0000, 1'b1, 16'h0001);

        // reset while commands are in flight
        cmd_valid = 1'b1;
        rand_cmd();
        step();
        rand_cmd();
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_res", {11'd0, res_valid, res_data, res_flags, res_divzero}, 32'd0);
        check("mid_rst_cnt", {29'd0, cmd_count}, 32'd0);
        check("mid_rst_sel", {28'd0, alu_sel}, 32'hF);
        check("mid_rst_ab", {alu_a, alu_b}, 32'd0);
        check("mid_rst_rdy", {31'd0, cmd_ready}, 32'd0);
        expq.delete();
        @(negedge clock);
        reset = 1'b1;
        res_ready = 1'b1;
        step();
        check("mid_rel_rdy", {31'd0, cmd_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            check("stale_res", {31'd0, res_valid}, 32'd0);
            step();
        end

        // backpressure
        for (int i = 0; i < 8; i++) begin
            bp_op[i] = 4'($urandom_range(0, 5));
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
        end
        res_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 14; c++) begin
            cmd_valid = (n_acc < 8);
            cmd_op = bp_op[n_acc % 8];
            cmd_a = bp_a[n_acc % 8];
            cmd_b = bp_b[n_acc % 8];
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) n_acc++;
            if (c >= 9)
                check("bp_idle_sel", {28'd0, alu_sel}, 32'hF);
        end
        check("bp_accepts", n_acc, 32'd7);
        check("bp_count", {29'd0, cmd_count}, 32'd4);
        check("bp_ready", {31'd0, cmd_ready}, 32'd0);
        check("bp_resv", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        for (int c = 0; c < 40 && (n_acc < 8 || expq.size() > 0); c++) begin
            cmd_valid = (n_acc < 8);
            cmd_op = bp_op[n_acc % 8];
            cmd_a = bp_a[n_acc % 8];
            cmd_b = bp_b[n_acc % 8];
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) n_acc++;
        end
        check("bp_eighth", n_acc, 32'd8);
        drain("bp_drain");

        // streaming with steady ready
        accepts = 0;
        pops = 0;
        sent = 0;
        res_ready = 1'b1;
        rand_cmd();
        for (int c = 0; c < 80 && sent < 16; c++) begin
            cmd_valid = 1'b1;
            acc = cmd_ready;
            step();
            if (acc) begin
                sent++;
                rand_cmd();
            end
        end
        drain("stream_drain");
        check("stream_cnt", pops, 32'd16);

        // streaming with random valid and ready
        accepts = 0;
        pops = 0;
        sent = 0;
        for (int c = 0; c < 200 && sent < 16; c++) begin
            rand_cmd();
            cmd_valid = 1'($urandom);
            res_ready = 1'($urandom);
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) sent++;
        end
        drain("toggle_drain");
        check("toggle_cnt", pops, accepts);
        check("toggle_sent", sent, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
